// File: rtl/apb_mem_slave_ws.sv
// APB word-organised memory slave with byte strobes, configurable wait
// states, error response on misaligned or out-of-range addresses, and
// registered response outputs (o_pready / o_pslverr / o_prdata).
module apb_mem_slave_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [ADDR_W-1:0]   i_paddr,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic                i_pwrite,
  input  logic [DATA_W-1:0]   i_pwdata,
  input  logic [DATA_W/8-1:0] i_pstrb,
  output logic [DATA_W-1:0]   o_prdata,
  output logic                o_pready,
  output logic                o_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Misaligned byte address or word index beyond the memory.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx      = a >> SHIFT;
    addr_err = ((a & ADDR_W'(STRB_W - 1)) != '0) || (idx >= ADDR_W'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [DATA_W-1:0] wdata_r;
  logic [STRB_W-1:0] strb_r;
  logic              err_r;

  logic              cap_en_s;
  logic              load_out_s;
  logic              use_live_s;
  logic              wr_commit_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_write_s;
  logic              sel_err_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [IDX_W-1:0]  wr_idx_s;

  // State register and wait counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic, capture/response strobes and write commit decision.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cap_en_s     = 1'b0;
    load_out_s   = 1'b0;
    use_live_s   = 1'b0;
    wr_commit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_psel && !i_penable) begin
          cap_en_s = 1'b1;
          if (WAIT_STATES == 0) begin
            // No wait states: the response is built straight from the bus.
            state_next_s = ST_DONE;
            load_out_s   = 1'b1;
            use_live_s   = 1'b1;
          end else begin
            state_next_s = ST_WAIT;
            cnt_next_s   = CNT_W'(WAIT_STATES - 1);
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!i_psel || !i_penable) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = ST_DONE;
          load_out_s   = 1'b1;
        end else begin
          cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        if (i_psel && i_penable && write_r && !err_r) begin
          wr_commit_s = 1'b1;
        end else begin
          wr_commit_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Pick live bus values (zero-wait) or captured values for the response.
  always_comb begin
    sel_addr_s  = addr_r;
    sel_write_s = write_r;
    sel_err_s   = err_r;
    if (use_live_s) begin
      sel_addr_s  = i_paddr;
      sel_write_s = i_pwrite;
      sel_err_s   = addr_err(i_paddr);
    end else begin
      sel_addr_s  = addr_r;
      sel_write_s = write_r;
      sel_err_s   = err_r;
    end
    sel_idx_s = IDX_W'(sel_addr_s >> SHIFT);
    wr_idx_s  = IDX_W'(addr_r >> SHIFT);
  end

  // Capture the setup-phase transfer attributes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      strb_r  <= {STRB_W{1'b0}};
      err_r   <= 1'b0;
    end else if (cap_en_s) begin
      addr_r  <= i_paddr;
      write_r <= i_pwrite;
      wdata_r <= i_pwdata;
      strb_r  <= i_pstrb;
      err_r   <= addr_err(i_paddr);
    end
  end

  // Registered response: valid only for the single DONE cycle, else zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= {DATA_W{1'b0}};
    end else if (load_out_s) begin
      o_pready  <= 1'b1;
      o_pslverr <= sel_err_s;
      o_prdata  <= (!sel_write_s && !sel_err_s) ? mem[sel_idx_s] : {DATA_W{1'b0}};
    end else begin
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= {DATA_W{1'b0}};
    end
  end

  // Byte-lane write commit at the edge that ends DONE; contents never reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < STRB_W; k++) begin
      if (wr_commit_s && strb_r[k]) begin
        mem[wr_idx_s][k*8 +: 8] <= wdata_r[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench: three slave instances with 0, 3 and 2 wait states share
// the APB bus; each has its own select line.
module tb_apb_mem_slave_ws;

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_mem_slave_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_psel(psel[0]),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata[0]), .o_pready(pready[0]), .o_pslverr(pslverr[0]));

  apb_mem_slave_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_psel(psel[1]),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata[1]), .o_pready(pready[1]), .o_pslverr(pslverr[1]));

  apb_mem_slave_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_psel(psel[2]),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata[2]), .o_pready(pready[2]), .o_pslverr(pslverr[2]));

  // One APB transfer on instance u. lat = access cycle (1-based) in which
  // pready was seen, 0 on timeout. early_nz flags nonzero prdata/pslverr
  // while pready was low. The bus is left in the access phase on return.
  task automatic xfer(input int u, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err,
                      output int lat, output logic early_nz);
    @(posedge clk); #1;
    psel = 3'b000; psel[u] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; early_nz = 1'b0; rd = 32'h0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (pready[u] === 1'b1) begin
        lat = n; rd = prdata[u]; err = pslverr[u];
        break;
      end
      if (prdata[u] !== 32'h0 || pslverr[u] !== 1'b0) early_nz = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if (pready[u] !== 1'b0 || pslverr[u] !== 1'b0 || prdata[u] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs u%0d: got rdy=%b err=%b data=%h expected 0/0/0",
                 u, pready[u], pslverr[u], prdata[u]);
      end
    end
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pready !== 3'b000 || pslverr !== 3'b000 || prdata[0] !== 32'h0 ||
          prdata[1] !== 32'h0 || prdata[2] !== 32'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: got nonzero output on idle bus, expected all 0");
    end
  endtask

  task automatic test_basic_ws0();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL ws0_write: got lat=%0d err=%b data=%h expected 1/0/00000000", lat, err, rd);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ws0_read: got lat=%0d err=%b data=%h expected 1/0/deadbeef", lat, err, rd);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, lat, nz);
    bus_idle();
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, err, lat, nz);
    bus_idle();
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (rd !== 32'h11BB33DD || err !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_merge: got data=%h err=%b expected 11bb33dd/0", rd, err);
    end
    // Zero strobe completes OKAY without touching memory.
    xfer(0, 1'b1, 32'h10, 32'h00000000, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_strobe_resp: got lat=%0d err=%b expected 1/0", lat, err);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL zero_strobe_mem: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(0, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, rd, err, lat, nz);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, nz);
    xfer(0, 1'b1, 32'h34, 32'h0F0F0F0F, 4'hF, rd, err, lat, nz);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_write_lat: got %0d expected 1", lat);
    end
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 1 || rd !== 32'h5A5A1234) begin
      n_fail++;
      $display("FAIL b2b_raw: got lat=%0d data=%h expected 1/5a5a1234", lat, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 4 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ws3_write_lat: got lat=%0d err=%b expected 4/0", lat, err);
    end
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL ws3_read_lat: got %0d expected 4", lat);
    end
    n_checks++;
    if (nz !== 1'b0) begin
      n_fail++;
      $display("FAIL ws3_early_data: got nonzero output before pready, expected 0");
    end
    n_checks++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ws3_read_data: got data=%h err=%b expected cafef00d/0", rd, err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(0, 1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, rd, err, lat, nz);
    bus_idle();
    xfer(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_misaligned: got lat=%0d err=%b data=%h expected 1/1/0", lat, err, rd);
    end
    xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_range: got err=%b expected 1", err);
    end
    // Misaligned address inside the last word must not write it.
    xfer(0, 1'b1, 32'h3FD, 32'hFFFFFFFF, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_misaligned_inrange: got err=%b expected 1", err);
    end
    xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (rd !== 32'h0BADC0DE || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_last_word: got data=%h err=%b expected 0badc0de/0", rd, err);
    end
    xfer(0, 1'b0, 32'h401, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_read: got data=%h err=%b expected 0/1", rd, err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lat; logic nz; logic seen;
    xfer(2, 1'b1, 32'h8, 32'h12345678, 4'hF, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL ws2_lat: got %0d expected 3", lat);
    end
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[2] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_ready: got pready after abort, expected none");
    end
    xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (rd !== 32'h12345678 || lat !== 3) begin
      n_fail++;
      $display("FAIL abort_mem: got data=%h lat=%0d expected 12345678/3", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat; logic nz;
    xfer(2, 1'b1, 32'hC, 32'h0000AAAA, 4'hF, rd, err, lat, nz);
    bus_idle();
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
    pwdata = 32'h99999999; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b err=%b data=%h expected 0/0/0",
               pready[2], pslverr[2], prdata[2]);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got pready=%b expected 0", pready[2]);
    end
    psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, 32'hC, 32'h0, 4'h0, rd, err, lat, nz);
    bus_idle();
    n_checks++;
    if (rd !== 32'h0000AAAA || lat !== 3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: got data=%h lat=%0d err=%b expected 0000aaaa/3/0",
               rd, lat, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ws0();
    test_strobes();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
